// File: rtl/vga_rx_pkg.sv
// rtl/vga_rx_pkg.sv - shared types and mode constants for the VGA receive monitor
package vga_rx_pkg;

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} lock_state_t;

    // 640x480@72 display mode, same porch/sync split as the transmit side
    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 24;
    localparam int H_SYNC    = 40;
    localparam int H_BACK    = 128;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 9;
    localparam int V_SYNC    = 3;
    localparam int V_BACK    = 28;

    localparam int H_TOTAL_EXP  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int H_ACTIVE_EXP = H_VISIBLE;
    localparam int V_TOTAL_EXP  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int V_ACTIVE_EXP = V_VISIBLE;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/vga_crc16.sv
// rtl/vga_crc16.sv - combinational CRC-16/CCITT-FALSE step over one byte, MSB first
module vga_crc16
    import vga_rx_pkg::*;
(
    input  logic [15:0] crc,
    input  logic [7:0]  data,
    output logic [15:0] crc_next
);

    logic [15:0] c;

    always_comb begin
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? CRC_POLY : 16'h0000);
        end
        crc_next = c;
    end

endmodule

// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - VGA receive monitor: pixel coordinates, timing measurement, lock FSM, frame CRC
module vga_rx_monitor
    import vga_rx_pkg::*;
#(
    parameter bit HSYNC_POL   = 1'b0,
    parameter bit VSYNC_POL   = 1'b0,
    parameter int CNT_W       = 12,
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int LOCK_FRAMES = 2,
    parameter int H_TOTAL     = H_TOTAL_EXP,
    parameter int H_ACTIVE    = H_ACTIVE_EXP,
    parameter int V_TOTAL     = V_TOTAL_EXP,
    parameter int V_ACTIVE    = V_ACTIVE_EXP
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             activevideo,
    input  logic [5:0]       rrggbb,
    input  logic             err_clr,
    output logic             pix_valid,
    output logic [X_W-1:0]   pix_x,
    output logic [Y_W-1:0]   pix_y,
    output logic [5:0]       pix_rrggbb,
    output logic             frame_done,
    output logic [15:0]      frame_crc,
    output logic [CNT_W-1:0] meas_h_total,
    output logic [CNT_W-1:0] meas_h_active,
    output logic [CNT_W-1:0] meas_v_total,
    output logic [CNT_W-1:0] meas_v_active,
    output logic             locked,
    output logic             lock_err
);

    localparam int M_W = $clog2(LOCK_FRAMES + 1);

    logic             hs_q, hs_qq, vs_q, vs_qq;
    logic [CNT_W-1:0] h_cnt, line_act, line_cnt, v_act_cnt;
    logic [15:0]      crc_reg, crc_step;
    logic             frame_ok_acc;
    lock_state_t      state;
    logic [M_W-1:0]   match_cnt;

    logic             hs_in, vs_in, hs_edge, vs_edge, timeout;
    logic             line_nz, line_bad, frame_ok;
    logic [CNT_W-1:0] h_total_now, v_total_now, v_act_now;
    logic [15:0]      crc_now;

    assign hs_in   = (hsync == HSYNC_POL);
    assign vs_in   = (vsync == VSYNC_POL);
    assign hs_edge = hs_q & ~hs_qq;
    assign vs_edge = vs_q & ~vs_qq;
    assign timeout = (h_cnt == {CNT_W{1'b1}}) & ~hs_edge;

    // A coincident hs edge still belongs to the frame that the vs edge closes
    assign h_total_now = h_cnt + CNT_W'(1);
    assign line_nz     = (line_act != '0);
    assign line_bad    = hs_edge & ((h_total_now != CNT_W'(H_TOTAL)) |
                                    (line_nz & (line_act != CNT_W'(H_ACTIVE))));
    assign v_total_now = line_cnt + CNT_W'(hs_edge);
    assign v_act_now   = v_act_cnt + CNT_W'(hs_edge & line_nz);
    assign crc_now     = pix_valid ? crc_step : crc_reg;
    assign frame_ok    = frame_ok_acc & ~line_bad &
                         (v_total_now == CNT_W'(V_TOTAL)) &
                         (v_act_now == CNT_W'(V_ACTIVE));

    vga_crc16 u_crc (
        .crc      (crc_reg),
        .data     ({2'b00, pix_rrggbb}),
        .crc_next (crc_step)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hs_q       <= 1'b0;
            hs_qq      <= 1'b0;
            vs_q       <= 1'b0;
            vs_qq      <= 1'b0;
            pix_valid  <= 1'b0;
            pix_rrggbb <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
        end else begin
            hs_q       <= hs_in;
            hs_qq      <= hs_q;
            vs_q       <= vs_in;
            vs_qq      <= vs_q;
            pix_valid  <= activevideo;
            pix_rrggbb <= rrggbb;
            pix_x      <= (activevideo & pix_valid) ? pix_x + X_W'(1) : '0;
            if (vs_in & ~vs_q)
                pix_y <= '0;
            else if (pix_valid & ~activevideo)
                pix_y <= pix_y + Y_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_cnt         <= '0;
            line_act      <= '0;
            line_cnt      <= '0;
            v_act_cnt     <= '0;
            crc_reg       <= CRC_INIT;
            frame_ok_acc  <= 1'b0;
            meas_h_total  <= '0;
            meas_h_active <= '0;
            meas_v_total  <= '0;
            meas_v_active <= '0;
            frame_crc     <= '0;
        end else begin
            if (hs_edge) begin
                meas_h_total <= h_total_now;
                h_cnt        <= '0;
                if (line_nz)
                    meas_h_active <= line_act;
                line_act <= CNT_W'(pix_valid);
            end else begin
                if (h_cnt != {CNT_W{1'b1}})
                    h_cnt <= h_cnt + CNT_W'(1);
                if (pix_valid)
                    line_act <= line_act + CNT_W'(1);
            end

            if (timeout) begin
                line_cnt     <= '0;
                v_act_cnt    <= '0;
                crc_reg      <= CRC_INIT;
                frame_ok_acc <= 1'b0;
            end else if (vs_edge) begin
                meas_v_total  <= v_total_now;
                meas_v_active <= v_act_now;
                frame_crc     <= crc_now;
                line_cnt      <= '0;
                v_act_cnt     <= '0;
                crc_reg       <= CRC_INIT;
                frame_ok_acc  <= 1'b1;
            end else begin
                line_cnt  <= v_total_now;
                v_act_cnt <= v_act_now;
                crc_reg   <= crc_now;
                if (line_bad)
                    frame_ok_acc <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= SEARCH;
            match_cnt  <= '0;
            frame_done <= 1'b0;
            locked     <= 1'b0;
            lock_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (err_clr)
                lock_err <= 1'b0;
            if (timeout) begin
                state     <= SEARCH;
                locked    <= 1'b0;
                match_cnt <= '0;
            end else if (vs_edge) begin
                case (state)
                    SEARCH: begin
                        state     <= MEASURE;
                        match_cnt <= '0;
                    end
                    MEASURE: begin
                        frame_done <= 1'b1;
                        if (frame_ok) begin
                            match_cnt <= match_cnt + M_W'(1);
                            if (int'(match_cnt) + 1 >= LOCK_FRAMES) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        frame_done <= 1'b1;
                        if (!frame_ok) begin
                            lock_err  <= 1'b1;
                            state     <= MEASURE;
                            match_cnt <= '0;
                            locked    <= 1'b0;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb/tb_vga_rx_monitor.sv - directed self-checking bench for vga_rx_monitor on a reduced video mode
module tb_vga_rx_monitor;

    localparam int HT = 20;
    localparam int HA = 12;
    localparam int VT = 10;
    localparam int VA = 6;

    logic        clk = 1'b0;
    logic        reset_n, hsync, vsync, activevideo, err_clr;
    logic [5:0]  rrggbb;
    logic        pix_valid, frame_done, locked, lock_err;
    logic [9:0]  pix_x, pix_y;
    logic [5:0]  pix_rrggbb;
    logic [15:0] frame_crc;
    logic [11:0] meas_h_total, meas_h_active, meas_v_total, meas_v_active;

    int checks = 0;
    int errors = 0;

    int          done_cnt = 0;
    logic        done_locked, done_err;
    logic [15:0] exp_crc;
    logic [9:0]  first_x, first_y, probe_x, probe_y;
    logic [5:0]  probe_rgb;
    logic        probe_v;
    logic [93:0] snap;
    int          d0;

    always #5 clk = ~clk;

    vga_rx_monitor #(
        .HSYNC_POL   (1'b0),
        .VSYNC_POL   (1'b0),
        .CNT_W       (12),
        .X_W         (10),
        .Y_W         (10),
        .LOCK_FRAMES (2),
        .H_TOTAL     (HT),
        .H_ACTIVE    (HA),
        .V_TOTAL     (VT),
        .V_ACTIVE    (VA)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .hsync         (hsync),
        .vsync         (vsync),
        .activevideo   (activevideo),
        .rrggbb        (rrggbb),
        .err_clr       (err_clr),
        .pix_valid     (pix_valid),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_rrggbb    (pix_rrggbb),
        .frame_done    (frame_done),
        .frame_crc     (frame_crc),
        .meas_h_total  (meas_h_total),
        .meas_h_active (meas_h_active),
        .meas_v_total  (meas_v_total),
        .meas_v_active (meas_v_active),
        .locked        (locked),
        .lock_err      (lock_err)
    );

    always @(negedge clk) begin
        if (frame_done) begin
            done_cnt    = done_cnt + 1;
            done_locked = locked;
            done_err    = lock_err;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in ^ {d, 8'h00};
        for (int i = 0; i < 8; i++)
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    function automatic logic [93:0] out_vec();
        return {pix_valid, pix_x, pix_y, pix_rrggbb, frame_done, frame_crc,
                meas_h_total, meas_h_active, meas_v_total, meas_v_active, locked, lock_err};
    endfunction

    task automatic idle(input int n);
        hsync = 1'b1;
        vsync = 1'b1;
        activevideo = 1'b0;
        rrggbb = 6'h0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 0: pattern, 1: single pixel of 0 at (0,0), 2: no active pixels
    // vsync leading edge coincides with the hsync leading edge of line 7
    task automatic run_frame(input int mode, input int stretch, input int seed, input bit do_rst);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int ln = 0; ln < VT; ln++) begin
            for (int x = 0; x < ((ln == stretch) ? HT + 1 : HT); x++) begin
                bit         act;
                logic [5:0] px;
                act = (ln < VA) && (x < HA);
                if (mode == 1) act = (ln == 0) && (x == 0);
                if (mode == 2) act = 1'b0;
                px = (mode == 1) ? 6'd0 : 6'((x + 3 * ln + seed) & 63);
                activevideo = act;
                rrggbb = act ? px : 6'h0;
                hsync = !(x >= 14 && x < 17);
                vsync = !((ln == 7 && x >= 14) || ln == 8 || (ln == 9 && x < 14));
                if (act) c = crc_model(c, {2'b00, px});
                reset_n = !(do_rst && ln == 3 && x == 0);
                @(posedge clk);
                #1;
                if (ln == 0 && x == 0) begin
                    first_x = pix_x;
                    first_y = pix_y;
                end
                if (ln == 2 && x == 5) begin
                    probe_x = pix_x;
                    probe_y = pix_y;
                    probe_rgb = pix_rrggbb;
                    probe_v = pix_valid;
                end
                if (!reset_n) snap = out_vec();
            end
        end
        reset_n = 1'b1;
        exp_crc = c;
    endtask

    initial begin
        err_clr = 1'b0;
        reset_n = 1'b0;
        idle(3);
        chk("reset_outputs_zero", 32'(|out_vec()), 32'd0);
        reset_n = 1'b1;

        run_frame(0, -1, 1, 1'b0);
        chk("search_no_done", 32'(done_cnt), 32'd0);

        run_frame(0, -1, 2, 1'b0);
        chk("f2_done", 32'(done_cnt), 32'd1);
        chk("f2_not_locked", 32'(done_locked), 32'd0);
        chk("f2_crc", 32'(frame_crc), 32'(exp_crc));
        chk("h_total", 32'(meas_h_total), 32'd20);
        chk("h_active", 32'(meas_h_active), 32'd12);
        chk("v_total", 32'(meas_v_total), 32'd10);
        chk("v_active", 32'(meas_v_active), 32'd6);
        chk("probe_x", 32'(probe_x), 32'd5);
        chk("probe_y", 32'(probe_y), 32'd2);
        chk("probe_rgb", 32'(probe_rgb), 32'd13);
        chk("probe_valid", 32'(probe_v), 32'd1);

        run_frame(0, -1, 3, 1'b0);
        chk("f3_done", 32'(done_cnt), 32'd2);
        chk("lock_at_2nd_done", 32'(done_locked), 32'd1);
        chk("f3_no_err", 32'(done_err), 32'd0);

        run_frame(0, -1, 4, 1'b0);
        chk("f4_crc", 32'(frame_crc), 32'(exp_crc));
        chk("coinc_v_total", 32'(meas_v_total), 32'd10);
        chk("coinc_first_y", 32'(first_y), 32'd0);
        chk("coinc_first_x", 32'(first_x), 32'd0);
        chk("f4_still_locked", 32'(locked), 32'd1);

        run_frame(0, 3, 5, 1'b0);
        chk("stretch_done", 32'(done_cnt), 32'd4);
        chk("stretch_unlock", 32'(done_locked), 32'd0);
        chk("stretch_lock_err", 32'(done_err), 32'd1);

        run_frame(0, -1, 6, 1'b0);
        chk("relock_1_not_yet", 32'(done_locked), 32'd0);
        run_frame(0, -1, 7, 1'b0);
        chk("relock_2_locked", 32'(done_locked), 32'd1);
        chk("err_sticky", 32'(lock_err), 32'd1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("err_clr", 32'(lock_err), 32'd0);

        run_frame(1, -1, 0, 1'b0);
        chk("crc_one_zero_pixel", 32'(frame_crc), 32'hE1F0);
        chk("one_pix_h_active", 32'(meas_h_active), 32'd1);
        chk("one_pix_v_active", 32'(meas_v_active), 32'd1);
        chk("one_pix_unlock_err", 32'(lock_err), 32'd1);

        run_frame(2, -1, 0, 1'b0);
        chk("crc_empty", 32'(frame_crc), 32'hFFFF);
        chk("empty_v_active", 32'(meas_v_active), 32'd0);
        chk("empty_h_active_held", 32'(meas_h_active), 32'd1);

        run_frame(0, -1, 10, 1'b0);
        run_frame(0, -1, 11, 1'b0);
        chk("relock_before_timeout", 32'(locked), 32'd1);
        d0 = done_cnt;
        idle(4100);
        chk("timeout_unlock", 32'(locked), 32'd0);
        run_frame(0, -1, 12, 1'b0);
        chk("timeout_search_no_done", 32'(done_cnt), 32'(d0));
        run_frame(0, -1, 13, 1'b0);
        chk("timeout_next_done", 32'(done_cnt), 32'(d0 + 1));
        chk("timeout_next_crc", 32'(frame_crc), 32'(exp_crc));
        chk("timeout_next_unlocked", 32'(done_locked), 32'd0);

        d0 = done_cnt;
        run_frame(0, -1, 14, 1'b1);
        chk("midreset_outputs_zero", 32'(|snap), 32'd0);
        chk("midreset_no_done", 32'(done_cnt), 32'(d0));
        run_frame(0, -1, 15, 1'b0);
        chk("midreset_next_done", 32'(done_cnt), 32'(d0 + 1));
        chk("midreset_crc", 32'(frame_crc), 32'(exp_crc));
        chk("midreset_unlocked", 32'(locked), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
